application_selector_lcd_serial_rgb_driver: RTL and testbench

//  Downstream sink of the LCD 24->8 bit format adapter: consumes the 8-bit Avalon-ST byte stream
//  (3 bytes R,G,B per pixel, one packet per frame) and drives the panel's serial-RGB bus.

---
 rtl/application_selector_lcd_pkg.sv | 26 ++
 rtl/application_selector_lcd_byte_fifo.sv | 39 +++
 rtl/application_selector_lcd_serial_rgb_driver.sv | 94 +++++++++
 tb/tb_application_selector_lcd_serial_rgb_driver.sv | 135 +++++++++++++
 4 files changed

// File: rtl/application_selector_lcd_pkg.sv
// application_selector_lcd_pkg: shared state encoding, timing defaults and FIFO entry layout
package application_selector_lcd_pkg;
  localparam logic [1:0] SEEK       = 2'd0;
  localparam logic [1:0] WAIT_FRAME = 2'd1;
  localparam logic [1:0] RUN        = 2'd2;
  localparam int DEF_H_SYNC     = 1;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_H_ACTIVE   = 2400;
  localparam int DEF_H_FRONT    = 40;
  localparam int DEF_V_SYNC     = 1;
  localparam int DEF_V_BACK     = 31;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FRONT    = 13;
  localparam int DEF_FIFO_DEPTH = 16;
  typedef struct packed {
    logic       eop;
    logic       sop;
    logic [7:0] data;
  } fifo_entry_t;
  function automatic int h_total(input int s, input int b, input int a, input int f);
    return s + b + a + f;
  endfunction
  function automatic int v_total(input int s, input int b, input int a, input int f);
    return s + b + a + f;
  endfunction
endpackage

// File: rtl/application_selector_lcd_byte_fifo.sv
// application_selector_lcd_byte_fifo: show-ahead sync FIFO with flush
module application_selector_lcd_byte_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/application_selector_lcd_serial_rgb_driver.sv
// application_selector_lcd_serial_rgb_driver: Avalon-ST byte stream to serial-RGB panel timing
module application_selector_lcd_serial_rgb_driver
  import application_selector_lcd_pkg::*;
#(
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_startofpacket,
  input  logic       in_endofpacket,
  input  logic       in_empty,
  output logic       lcd_hsync_n,
  output logic       lcd_vsync_n,
  output logic       lcd_den,
  output logic [7:0] lcd_data,
  output logic       frame_done,
  output logic       sync_lost
);
  localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_FIRST = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_LAST  = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [VW-1:0] V_FIRST = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_LAST  = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0] state;
  logic active, first, last, check, err, done;
  logic push, pop, full, empty;
  logic unused;
  fifo_entry_t head, wdata;
  assign unused   = in_empty;
  assign active   = h_cnt >= H_FIRST && h_cnt <= H_LAST && v_cnt >= V_FIRST && v_cnt <= V_LAST;
  assign first    = h_cnt == H_FIRST && v_cnt == V_FIRST;
  assign last     = h_cnt == H_LAST && v_cnt == V_LAST;
  assign in_ready = state == SEEK || !full;
  assign push     = in_valid && in_ready && (state != SEEK || in_startofpacket);
  assign wdata    = '{eop: in_endofpacket, sop: in_startofpacket, data: in_data};
  // Every cycle that should consume a byte is checked for underflow and packet alignment
  assign check    = (state == RUN && active) || (state == WAIT_FRAME && first && !empty);
  assign err      = check && (empty || (head.sop && !first) || (head.eop != last));
  assign done     = check && !err && last;
  assign pop      = check && !empty;
  application_selector_lcd_byte_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (err),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      state       <= SEEK;
      lcd_hsync_n <= 1'b1;
      lcd_vsync_n <= 1'b1;
      lcd_den     <= 1'b0;
      lcd_data    <= 8'h00;
      frame_done  <= 1'b0;
      sync_lost   <= 1'b0;
    end else begin
      h_cnt <= h_cnt == HW'(H_TOTAL - 1) ? '0 : h_cnt + 1'b1;
      if (h_cnt == HW'(H_TOTAL - 1)) v_cnt <= v_cnt == VW'(V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
      state <= err ? SEEK :
               done ? WAIT_FRAME :
               (state == SEEK && push) ? WAIT_FRAME :
               (state == WAIT_FRAME && pop) ? RUN : state;
      lcd_hsync_n <= !(h_cnt < HW'(H_SYNC));
      lcd_vsync_n <= !(v_cnt < VW'(V_SYNC));
      lcd_den     <= active;
      lcd_data    <= pop ? head.data : 8'h00;
      frame_done  <= done;
      sync_lost   <= err;
    end
  end
endmodule

// File: tb/tb_application_selector_lcd_serial_rgb_driver.sv
// tb_application_selector_lcd_serial_rgb_driver: random packet stream against a frame-level model
module tb_application_selector_lcd_serial_rgb_driver;
  logic clk = 0, reset;
  logic in_ready, in_valid, in_startofpacket, in_endofpacket, in_empty;
  logic [7:0] in_data;
  logic lcd_hsync_n, lcd_vsync_n, lcd_den, frame_done, sync_lost;
  logic [7:0] lcd_data;
  int checks = 0, failures = 0;
  int t, mode;
  int q[$], stream[$];
  bit m_rdy, did_rst;
  logic e_hs, e_vs, e_den, e_done, e_lost;
  logic [7:0] e_data;
  int n_done = 0, n_lost = 0;

  application_selector_lcd_serial_rgb_driver #(
    .H_SYNC(2), .H_BACK(2), .H_ACTIVE(6), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket), .in_empty(in_empty),
    .lcd_hsync_n(lcd_hsync_n), .lcd_vsync_n(lcd_vsync_n), .lcd_den(lcd_den), .lcd_data(lcd_data),
    .frame_done(frame_done), .sync_lost(sync_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; mode = 0; q.delete();
    e_hs = 1; e_vs = 1; e_den = 0; e_data = 0; e_done = 0; e_lost = 0;
  endtask

  // Byte index within the frame (0..11) decides what must appear and where SOP/EOP belong
  task automatic model_step(input bit v_in, input int b);
    int h, v, idx, e;
    bit act, lost, done;
    h = t % 12; v = (t / 12) % 5;
    act = h >= 4 && h < 10 && v >= 2 && v < 4;
    idx = (v - 2) * 6 + (h - 4);
    lost = 0; done = 0; e_data = 0;
    if (act && (mode == 2 || (mode == 1 && idx == 0 && q.size() > 0))) begin
      if (q.size() == 0) lost = 1;
      else begin
        e = q.pop_front();
        e_data = e[7:0];
        if ((e[8] && idx != 0) || (e[9] != (idx == 11))) lost = 1;
        else begin
          if (idx == 11) done = 1;
          if (mode == 1) mode = 2;
        end
      end
    end
    if (v_in && m_rdy && !lost) begin
      if (mode != 0) q.push_back(b);
      else if (b[8]) begin q.push_back(b); mode = 1; end
    end
    if (lost) begin q.delete(); mode = 0; end
    if (done) mode = 1;
    e_den = act; e_hs = h >= 2; e_vs = v >= 1; e_done = done; e_lost = lost;
    t = (t + 1) % 60;
  endtask

  task automatic add_packet(input int kind);
    int k;
    k = $urandom_range(1, 11);
    case (kind)
      1: repeat ($urandom_range(1, 3)) stream.push_back($urandom_range(0, 255));
      2: for (int i = 0; i < k; i++) stream.push_back((i == k - 1 ? 512 : 0) | (i == 0 ? 256 : 0) | $urandom_range(0, 255));
      3: for (int i = 0; i < 12; i++) stream.push_back((i == 11 ? 512 : 0) | ((i == 0 || i == k) ? 256 : 0) | $urandom_range(0, 255));
      default: for (int i = 0; i < 12; i++) stream.push_back((i == 11 ? 512 : 0) | (i == 0 ? 256 : 0) | $urandom_range(0, 255));
    endcase
  endtask

  task automatic check_outputs();
    check("hsync_n", lcd_hsync_n, e_hs);
    check("vsync_n", lcd_vsync_n, e_vs);
    check("den", lcd_den, e_den);
    check("data", lcd_data, e_data);
    check("frame_done", frame_done, e_done);
    check("sync_lost", sync_lost, e_lost);
    if (e_done) n_done++;
    if (e_lost) n_lost++;
  endtask

  initial begin
    bit rst_now, stall, v_now;
    int b, r;
    reset = 1; in_valid = 0; in_data = 0; in_startofpacket = 0; in_endofpacket = 0; in_empty = 0;
    did_rst = 0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    check_outputs();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 120) begin
        stream.push_back(8'hAA);
        stream.push_back(8'hBB);
        for (int i = 1; i <= 12; i++) stream.push_back((i == 12 ? 512 : 0) | (i == 1 ? 256 : 0) | i);
      end else if (cyc > 120 && stream.size() < 2) begin
        r = $urandom_range(0, 9);
        add_packet(r < 6 ? 0 : r - 5);
      end
      rst_now = cyc >= 2000 && !did_rst && t == 30;
      if (rst_now) did_rst = 1;
      stall = $urandom_range(0, 49) == 0;
      v_now = stream.size() > 0 && !stall;
      b = v_now ? stream[0] : $urandom_range(0, 1023);
      in_valid = v_now;
      in_data = b[7:0];
      in_startofpacket = b[8];
      in_endofpacket = b[9];
      m_rdy = mode == 0 || q.size() < 4;
      check("in_ready", in_ready, m_rdy);
      if (v_now && m_rdy) void'(stream.pop_front());
      reset = rst_now;
      if (rst_now) model_reset();
      else model_step(v_now, b);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end
    check("frames_seen", n_done > 3, 1'b1);
    check("resyncs_seen", n_lost > 3, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
